// File: rtl/gerador_reset_pkg.sv
// Shared state encoding, reset-cause codes and sizing helper for the reset generator.
// Constants only; no logic, no latency.
package gerador_reset_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t ST_ASSERT = 2'd0;
    localparam estado_t ST_HOLD   = 2'd1;
    localparam estado_t ST_RUN    = 2'd2;

    localparam logic [1:0] CAUSA_POR = 2'b00;
    localparam logic [1:0] CAUSA_SW  = 2'b01;
    localparam logic [1:0] CAUSA_WDT = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_wdt.sv
// Watchdog counter: counts while enabled, kick/clr restart it; expira flags the timeout edge.
// expira is combinational from kick so a kick on the timeout edge still wins; no backpressure.
module contador_wdt #(
    parameter int WDT_CYC = 1024
) (
    input  logic clk_A,
    input  logic nrst_in,
    input  logic en,
    input  logic kick,
    input  logic clr,
    output logic expira
);

    localparam int         W      = $clog2(WDT_CYC);
    localparam logic [W-1:0] LIMITE = W'(WDT_CYC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || kick) begin
            cnt_d = '0;
        end else if (cnt_q != LIMITE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expira = en && !kick && !clr && (cnt_q == LIMITE);

    always_ff @(posedge clk_A) begin
        if (!nrst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gerador_reset.sv
// Reset generator: fixed-width nrst_out pulse on POR, software request or watchdog expiry, then hold-off.
// All outputs registered (one edge from sampled input); requests outside ST_RUN are dropped, never queued.
module gerador_reset
    import gerador_reset_pkg::*;
#(
    parameter int PULSE_CYC   = 16,
    parameter int HOLDOFF_CYC = 8,
    parameter int WDT_CYC     = 1024
) (
    input  logic       clk_A,
    input  logic       nrst_in,
    input  logic       req_sw,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       nrst_out,
    output logic       rst_ack,
    output logic [1:0] causa
);

    localparam int            CW        = $clog2(max_int(PULSE_CYC, HOLDOFF_CYC));
    localparam logic [CW-1:0] FIM_PULSO = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] FIM_HOLD  = CW'(HOLDOFF_CYC - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    causa_q, causa_d;
    logic          ack_q, ack_d;
    logic          nrst_out_q, nrst_out_d;
    logic          arranque_q;
    logic          expira;

    contador_wdt #(
        .WDT_CYC (WDT_CYC)
    ) u_wdt (
        .clk_A   (clk_A),
        .nrst_in (nrst_in),
        .en      (wdt_en),
        .kick    (wdt_kick),
        .clr     (estado_q != ST_RUN),
        .expira  (expira)
    );

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        causa_d  = causa_q;
        ack_d    = 1'b0;
        case (estado_q)
            ST_ASSERT: begin
                // The release edge after reset acts as the pulse start, so the counter holds there.
                if (req_sw || arranque_q) begin
                    cnt_d = '0;
                end else if (cnt_q == FIM_PULSO) begin
                    estado_d = ST_HOLD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == FIM_HOLD) begin
                    estado_d = ST_RUN;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (req_sw) begin
                    estado_d = ST_ASSERT;
                    cnt_d    = '0;
                    causa_d  = CAUSA_SW;
                    ack_d    = 1'b1;
                end else if (expira) begin
                    estado_d = ST_ASSERT;
                    cnt_d    = '0;
                    causa_d  = CAUSA_WDT;
                    ack_d    = 1'b1;
                end
            end
            default: begin
                estado_d = ST_ASSERT;
                cnt_d    = '0;
            end
        endcase
        nrst_out_d = (estado_d != ST_ASSERT);
    end

    always_ff @(posedge clk_A) begin
        if (!nrst_in) begin
            estado_q   <= ST_ASSERT;
            cnt_q      <= '0;
            causa_q    <= CAUSA_POR;
            ack_q      <= 1'b0;
            nrst_out_q <= 1'b0;
            arranque_q <= 1'b1;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            causa_q    <= causa_d;
            ack_q      <= ack_d;
            nrst_out_q <= nrst_out_d;
            arranque_q <= 1'b0;
        end
    end

    assign nrst_out = nrst_out_q;
    assign rst_ack  = ack_q;
    assign causa    = causa_q;

endmodule

// File: doc/gerador_reset.md
# gerador_reset

Reset generator and sequencer on the `clk_A` domain. It is the source end of the reset path: it drives the active-low reset `nrst_out` that downstream per-domain reset synchronizers consume asynchronously. It issues a fixed-width reset pulse after system reset, on a software request, and on watchdog expiry. It reports the cause of the last reset and enforces a hold-off window so that back-to-back requests cannot chatter the reset line.

## Interface
Parameters:
- `PULSE_CYC`, default 16 — `nrst_out` low width in `clk_A` cycles; must be ≥ 2.
- `HOLDOFF_CYC`, default 8 — cycles after release during which requests are ignored; must be ≥ 1.
- `WDT_CYC`, default 1024 — watchdog timeout in cycles; must be ≥ 2.

Ports:
- `clk_A` — in, 1 — single clock for the whole block.
- `nrst_in` — in, 1 — reset, synchronous, active-low.
- `req_sw` — in, 1 — software reset request, level-sampled each edge.
- `wdt_en` — in, 1 — watchdog enable.
- `wdt_kick` — in, 1 — watchdog restart, sampled each edge.
- `nrst_out` — out, 1 — generated reset, active-low, registered.
- `rst_ack` — out, 1 — one-cycle pulse when a request or expiry is accepted.
- `causa` — out, 2 — cause of the last reset: 00 POR, 01 SW, 10 WDT, 11 reserved (never driven).

## Operation
- The FSM has three states: `ST_ASSERT` (`nrst_out`=0), `ST_HOLD` (`nrst_out`=1, requests ignored) and `ST_RUN` (`nrst_out`=1, requests accepted).
- **Reset behaviour.** At any edge that samples `nrst_in`=0:
  - state = `ST_ASSERT`, pulse counter = 0, watchdog counter = 0;
  - `nrst_out`=0, `rst_ack`=0, `causa`=00.
  - This applies in every state, including mid-pulse and mid-hold-off.
- **`ST_ASSERT`.** The counter increments each cycle. When it reaches `PULSE_CYC`-1, the next edge moves to `ST_HOLD`, sets `nrst_out`=1 and clears the counter.
- **`ST_HOLD`.** The counter runs for `HOLDOFF_CYC` cycles, then the FSM moves to `ST_RUN`. `req_sw` and watchdog activity are ignored, and `rst_ack` stays 0.
- **`ST_RUN`, software request.** `req_sw`=1 at an edge causes:
  - move to `ST_ASSERT` with counter = 0;
  - `causa`=01 and `rst_ack`=1 for one cycle.
- **`ST_RUN`, watchdog.** While `wdt_en`=1:
  - the watchdog counter increments each cycle;
  - `wdt_kick`=1 clears it to 0;
  - if the counter equals `WDT_CYC`-1 and there is no kick at that edge, the FSM moves to `ST_ASSERT` with `causa`=10 and `rst_ack`=1.
  - With `wdt_en`=0 the counter holds at 0.
- **Simultaneous events:**
  - `req_sw` and watchdog expiry at the same edge: SW wins, `causa`=01.
  - `wdt_kick` and expiry at the same edge: the kick wins and no reset is issued.
- **`req_sw` during `ST_ASSERT`.** The pulse counter restarts at 0, which stretches the pulse. `causa` is unchanged and no `rst_ack` is issued.
- **Holding values.** `causa` keeps its value through `ST_HOLD`/`ST_RUN` until the next accepted event or reset.
- **Counter widths.** Widths are `$clog2` of the respective parameter. Counters saturate and never wrap.

## Timing
- **Power-on release.** Let E0 be the first edge sampling `nrst_in`=1.
  - `nrst_out` rises at edge E0+`PULSE_CYC`.
  - `ST_RUN` is entered at E0+`PULSE_CYC`+`HOLDOFF_CYC`.
  - The first request that can be accepted is at the following edge.
- **Software request.** With `req_sw` accepted at edge N:
  - `nrst_out` falls at N and rises at N+`PULSE_CYC`, so it is low for exactly `PULSE_CYC` cycles;
  - `rst_ack` is high during the cycle N..N+1.
- **Watchdog expiry.** With `ST_RUN` entered at edge R and `wdt_en` held at 1 with no kicks, expiry occurs at edge R+`WDT_CYC`.
- **Registered outputs.** All outputs are registered and there is no combinational path from input to output.

## Structure
- **Package `gerador_reset_pkg`:**
  - state enum (`ST_ASSERT`, `ST_HOLD`, `ST_RUN`);
  - `causa` codes `CAUSA_POR`, `CAUSA_SW`, `CAUSA_WDT`.
- **Sub-module `contador_wdt`:** the watchdog counter, with inputs `en`, `kick` and `clr` (the `clr` input is driven when the FSM is not in `ST_RUN`) and output `expira`. Parameter `WDT_CYC`.
- **Top level:** holds the FSM, the pulse/hold-off counter and the output registers.

## Test plan
All scenarios use `PULSE_CYC`=4, `HOLDOFF_CYC`=2, `WDT_CYC`=8.
- **Power-on.** Hold `nrst_in`=0 for 3 edges, then release (E0).
  - During reset: `nrst_out`=0 and `causa`=00.
  - `nrst_out`=1 at E0+4.
  - A `req_sw` at E0+5 is ignored (no `rst_ack`).
- **Software request.** Pulse `req_sw` in `ST_RUN` at edge N.
  - `rst_ack`=1 for one cycle and `causa`=01.
  - `nrst_out` is low N..N+4.
- **Watchdog.** Set `wdt_en`=1 with no kicks from RUN entry R.
  - Expiry at R+8: `causa`=10 and `nrst_out`=0.
  - Repeat with kicks every 5 cycles: no reset for 100 cycles.
- **Race cases.**
  - `wdt_kick` at the expiry edge: no reset.
  - `req_sw` at the expiry edge: `causa`=01.
- **Stretch.** `req_sw`=1 again two cycles into `ST_ASSERT`: `nrst_out` is low for 2+4=6 cycles total, and `rst_ack` pulses once.
- **Reset mid-operation.** Drive `nrst_in`=0 during `ST_HOLD`.
  - Next edge: `nrst_out`=0, `causa`=00, counters cleared.
  - A full `PULSE_CYC` sequence follows release.
